// File: rtl/chd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | chd_pkg                                                                    |
// | Shared types and widths for the canonical Huffman decoder.                 |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package chd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_BUILD  = 3'd2,
    ST_PLACE  = 3'd3,
    ST_DECODE = 3'd4
  } chd_state_t;

  localparam int LEN_W = 4;
  localparam int SYM_W = 8;
  localparam int CNT_W = $clog2(20 + 1);

endpackage : chd_pkg
`default_nettype wire

// File: rtl/chd_code_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | chd_code_table                                                             |
// | Canonical count / first_code / first_idx / sorted tables with a            |
// | combinational (acc, len) -> (hit, sym) lookup. Macro: CHD_KRAFT_CHECK_EN.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module chd_code_table
  import chd_pkg::*;
#(
  parameter int MAX_SYMS = 20,
  parameter int MAX_LEN  = 15,
  parameter int CW       = CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               inc_en,
  input  logic [LEN_W-1:0]   inc_len,
  input  logic               build_en,
  input  logic [LEN_W-1:0]   build_len,
  input  logic               place_en,
  input  logic [SYM_W-1:0]   place_sym,
  input  logic [LEN_W-1:0]   place_len,
  input  logic [MAX_LEN-1:0] look_acc,
  input  logic [LEN_W-1:0]   look_len,
  output logic               hit,
  output logic [SYM_W-1:0]   hit_sym,
  output logic               kraft_over
);

  localparam int FC_W = MAX_LEN + 1;
`ifdef CHD_KRAFT_CHECK_EN
  // Extra headroom so an oversubscribed table cannot wrap below 2^MAX_LEN.
  localparam int CODE_W = FC_W + CW;
`else
  localparam int CODE_W = FC_W;
`endif

  // Index 0 is never incremented, so count[0] reads as 0 during BUILD.
  logic [CW-1:0]     count      [0:MAX_LEN];
  logic [FC_W-1:0]   first_code [0:MAX_LEN];
  logic [CW-1:0]     first_idx  [0:MAX_LEN];
  logic [CW-1:0]     off        [0:MAX_LEN];
  logic [SYM_W-1:0]  sorted     [0:MAX_SYMS-1];
  logic [CODE_W-1:0] code_r;
  logic [CW-1:0]     idx_r;

  logic [CODE_W-1:0] code_nxt;
  logic [FC_W-1:0]   diff;
  logic [CW-1:0]     sel;

  assign code_nxt = (code_r + CODE_W'(count[build_len - LEN_W'(1)])) << 1;

`ifdef CHD_KRAFT_CHECK_EN
  assign kraft_over = build_en && (build_len == LEN_W'(MAX_LEN)) &&
                      ((code_nxt + CODE_W'(count[MAX_LEN])) > (CODE_W'(1) << MAX_LEN));
`else
  assign kraft_over = 1'b0;
`endif

  always_comb begin
    diff    = {1'b0, look_acc} - first_code[look_len];
    sel     = first_idx[look_len] + diff[CW-1:0];
    hit     = (look_len != '0) && (diff < FC_W'(count[look_len]));
    hit_sym = (sel < CW'(MAX_SYMS)) ? sorted[sel] : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i <= MAX_LEN; i++) begin
        count[i]      <= '0;
        first_code[i] <= '0;
        first_idx[i]  <= '0;
        off[i]        <= '0;
      end
      for (int i = 0; i < MAX_SYMS; i++) sorted[i] <= '0;
      code_r <= '0;
      idx_r  <= '0;
    end else if (clr) begin
      for (int i = 0; i <= MAX_LEN; i++) begin
        count[i]      <= '0;
        first_code[i] <= '0;
        first_idx[i]  <= '0;
        off[i]        <= '0;
      end
      for (int i = 0; i < MAX_SYMS; i++) sorted[i] <= '0;
      code_r <= '0;
      idx_r  <= '0;
    end else begin
      if (inc_en) begin
        count[inc_len] <= count[inc_len] + CW'(1);
      end
      if (build_en) begin
        code_r                <= code_nxt;
        first_code[build_len] <= code_nxt[FC_W-1:0];
        first_idx[build_len]  <= idx_r;
        off[build_len]        <= idx_r;
        idx_r                 <= idx_r + count[build_len];
      end
      if (place_en && (off[place_len] < CW'(MAX_SYMS))) begin
        sorted[off[place_len]] <= place_sym;
        off[place_len]         <= off[place_len] + CW'(1);
      end
    end
  end

endmodule : chd_code_table
`default_nettype wire

// File: rtl/canonical_huffman_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | canonical_huffman_decoder                                                  |
// | Loads (symbol, length) pairs, builds canonical tables, decodes a serial    |
// | MSB-first bitstream into symbols. Optional macro: CHD_KRAFT_CHECK_EN.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module canonical_huffman_decoder
  import chd_pkg::*;
#(
  parameter int MAX_SYMS = 20,
  parameter int MAX_LEN  = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             len_pulse,
  input  logic [SYM_W-1:0] len_syml,
  input  logic [LEN_W-1:0] len_val,
  input  logic             len_done,
  input  logic             tbl_clr,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             bit_ready,
  output logic [SYM_W-1:0] sym_out,
  output logic             sym_valid,
  output logic             tbl_ready,
  output logic             ovf,
  output logic             err
);

  localparam int CW = ($clog2(MAX_SYMS + 1) > CNT_W) ? $clog2(MAX_SYMS + 1) : CNT_W;

  chd_state_t state, state_nxt;

  logic [SYM_W-1:0]   ent_sym [0:MAX_SYMS-1];
  logic [LEN_W-1:0]   ent_len [0:MAX_SYMS-1];
  logic [CW-1:0]      entries;
  logic [CW-1:0]      place_ptr;
  logic [LEN_W-1:0]   build_len;
  logic               locked;
  logic [MAX_LEN-2:0] acc;
  logic [MAX_LEN-1:0] acc_nxt;
  logic [LEN_W-1:0]   n;
  logic [LEN_W-1:0]   n_nxt;

  logic pulse_ok, store, ovf_set, build_en, build_last, place_en, accept, kraft_fail;
  logic hit, kraft_over;
  logic [SYM_W-1:0] hit_sym;

  assign acc_nxt    = {acc, bit_in};
  assign n_nxt      = n + LEN_W'(1);
  assign build_last = (build_len == LEN_W'(MAX_LEN));
  assign store      = pulse_ok && (len_val != '0) && (entries < CW'(MAX_SYMS));
  assign ovf_set    = pulse_ok && (entries == CW'(MAX_SYMS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pulse_ok   = 1'b0;
    build_en   = 1'b0;
    place_en   = 1'b0;
    accept     = 1'b0;
    kraft_fail = 1'b0;
    bit_ready  = 1'b0;
    tbl_ready  = 1'b0;
    case (state)
      ST_IDLE: begin
        // A failed Kraft check parks the block here until tbl_clr.
        if (len_pulse && !locked) begin
          pulse_ok  = 1'b1;
          state_nxt = len_done ? ST_BUILD : ST_LOAD;
        end
      end
      ST_LOAD: begin
        pulse_ok = len_pulse;
        if (len_done) state_nxt = ST_BUILD;
      end
      ST_BUILD: begin
        build_en = 1'b1;
        if (build_last) begin
          kraft_fail = kraft_over;
          state_nxt  = kraft_over ? ST_IDLE : ST_PLACE;
        end
      end
      ST_PLACE: begin
        place_en = (entries != '0);
        if ((entries == '0) || (place_ptr == entries - CW'(1))) state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        bit_ready = 1'b1;
        tbl_ready = 1'b1;
        accept    = bit_valid;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (tbl_clr) begin
      state_nxt  = ST_IDLE;
      pulse_ok   = 1'b0;
      build_en   = 1'b0;
      place_en   = 1'b0;
      accept     = 1'b0;
      kraft_fail = 1'b0;
      bit_ready  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entries <= '0;
      for (int i = 0; i < MAX_SYMS; i++) begin
        ent_sym[i] <= '0;
        ent_len[i] <= '0;
      end
    end else if (tbl_clr) begin
      entries <= '0;
      for (int i = 0; i < MAX_SYMS; i++) begin
        ent_sym[i] <= '0;
        ent_len[i] <= '0;
      end
    end else if (store) begin
      ent_sym[entries] <= len_syml;
      ent_len[entries] <= len_val;
      entries          <= entries + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      build_len <= LEN_W'(1);
      place_ptr <= '0;
      locked    <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (ovf_set) ovf <= 1'b1;
      if (tbl_clr) begin
        build_len <= LEN_W'(1);
        place_ptr <= '0;
        locked    <= 1'b0;
      end else begin
        if (build_en) build_len <= build_last ? LEN_W'(1) : build_len + LEN_W'(1);
        if (place_en) place_ptr <= (state_nxt == ST_DECODE) ? '0 : place_ptr + CW'(1);
        if (kraft_fail) locked <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      n         <= '0;
      sym_out   <= '0;
      sym_valid <= 1'b0;
      err       <= 1'b0;
    end else if (tbl_clr) begin
      acc       <= '0;
      n         <= '0;
      sym_out   <= '0;
      sym_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      sym_valid <= 1'b0;
      err       <= kraft_fail;
      if (accept) begin
        if (hit) begin
          sym_valid <= 1'b1;
          sym_out   <= hit_sym;
          acc       <= '0;
          n         <= '0;
        end else if (n_nxt == LEN_W'(MAX_LEN)) begin
          err <= 1'b1;
          acc <= '0;
          n   <= '0;
        end else begin
          acc <= acc_nxt[MAX_LEN-2:0];
          n   <= n_nxt;
        end
      end
    end
  end

  chd_code_table #(
    .MAX_SYMS (MAX_SYMS),
    .MAX_LEN  (MAX_LEN),
    .CW       (CW)
  ) u_table (
    .clk        (clk),
    .reset      (reset),
    .clr        (tbl_clr),
    .inc_en     (store),
    .inc_len    (len_val),
    .build_en   (build_en),
    .build_len  (build_len),
    .place_en   (place_en),
    .place_sym  (ent_sym[place_ptr]),
    .place_len  (ent_len[place_ptr]),
    .look_acc   (acc_nxt),
    .look_len   (n_nxt),
    .hit        (hit),
    .hit_sym    (hit_sym),
    .kraft_over (kraft_over)
  );

endmodule : canonical_huffman_decoder
`default_nettype wire
